// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions and the serialiser state encoding.
package mmio_uart_pkg;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;
  localparam logic [1:0] REG_RSVD    = 2'd3;

  localparam int ST_BUSY    = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_EMPTY   = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 4;
  localparam int ST_CNT_MSB = 7;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; pointers carry one extra wrap bit so full and empty differ.
// A push while full is still accepted when a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr;
  logic             do_push, do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rptr[AW-1:0]];
  assign count = wptr - rptr;
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: stores to TXDATA queue bytes in a FIFO,
// loads return status/config combinationally so the core keeps single-cycle timing.
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
  parameter int          DEPTH     = 8,
  parameter logic [15:0] DIV_RESET = 16'd434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        sel,
  output logic        tx
);

  localparam int AW = $clog2(DEPTH);

  tx_state_t   state, state_nx;
  logic [15:0] div, baud;
  logic [2:0]  bitcnt;
  logic [7:0]  shift, head;
  logic        ovf;
  logic [1:0]  off;
  logic        push, pop, full, empty, bit_end;
  logic        wr_status, wr_div;
  logic [AW:0] count;
  logic        unused_bits;

  function automatic logic [3:0] sat_cnt(input logic [AW:0] c);
    return (int'(c) > 15) ? 4'd15 : 4'(c);
  endfunction

  assign sel       = (a[31:4] == BASE_ADDR[31:4]);
  assign off       = a[3:2];
  assign push      = we && sel && (off == REG_TXDATA);
  assign wr_status = we && sel && (off == REG_STATUS);
  assign wr_div    = we && sel && (off == REG_BAUDDIV);
  assign pop       = (state == IDLE) && !empty;
  assign bit_end   = (baud == 16'd0);
  assign unused_bits = ^{a[1:0], wd[31:16]};

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (wd[7:0]),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    tx       = 1'b1;
    case (state)
      IDLE:  if (!empty) state_nx = START;
      START: begin
        tx = 1'b0;
        if (bit_end) state_nx = DATA;
      end
      DATA: begin
        tx = shift[0];
        if (bit_end && bitcnt == 3'd7) state_nx = STOP;
      end
      STOP:  if (bit_end) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Baud timing always reloads from the live divisor, so a divisor write lands at the next bit boundary
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      baud   <= '0;
      bitcnt <= '0;
      div    <= DIV_RESET;
      ovf    <= 1'b0;
    end else begin
      if (pop)                 baud <= div - 16'd1;
      else if (state != IDLE)  baud <= bit_end ? div - 16'd1 : baud - 16'd1;
      if (state == DATA && bit_end) bitcnt <= bitcnt + 3'd1;
      if (wr_div) div <= (wd[15:0] == 16'd0) ? 16'd1 : wd[15:0];
      if (wr_status && wd[ST_OVF])    ovf <= 1'b0;
      else if (push && full && !pop)  ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (pop)                            shift <= head;
    else if (state == DATA && bit_end)  shift <= {1'b0, shift[7:1]};
  end

  always_comb begin
    rd = '0;
    if (sel) begin
      case (off)
        REG_STATUS: begin
          rd[ST_BUSY]                = (state != IDLE);
          rd[ST_FULL]                = full;
          rd[ST_EMPTY]               = empty;
          rd[ST_OVF]                 = ovf;
          rd[ST_CNT_MSB:ST_CNT_LSB]  = sat_cnt(count);
        end
        REG_BAUDDIV: rd[15:0] = div;
        default:     rd = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: each queued byte pushes an expected frame,
// a UART monitor decodes tx and checks every bit level and duration.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE     = 32'h0000_0400;
  localparam logic [31:0] A_TXDATA = BASE + 32'd0;
  localparam logic [31:0] A_STATUS = BASE + 32'd4;
  localparam logic [31:0] A_DIV    = BASE + 32'd8;
  localparam logic [31:0] A_RSVD   = BASE + 32'd12;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        we = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] wd = '0;
  logic [31:0] rd;
  logic        sel, tx;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct packed {
    logic [7:0]      data;
    logic [9:0][7:0] lens;
  } frame_t;

  frame_t exp_q[$];
  int     starts[$];

  mmio_uart_tx #(.BASE_ADDR(BASE), .DEPTH(8), .DIV_RESET(16'd434)) dut (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .a     (a),
    .wd    (wd),
    .rd    (rd),
    .sel   (sel),
    .tx    (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic frame_t mk(input logic [7:0] d, input int first, input int rest);
    frame_t f;
    f.data = d;
    for (int i = 0; i < 10; i++) f.lens[i] = 8'((i == 0) ? first : rest);
    return f;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] expv);
    we = 1'b0;
    a  = addr;
    #1;
    check(name, rd, expv);
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, output int en);
    a  = addr;
    wd = data;
    we = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
    en = cyc;
  endtask

  task automatic wait_cyc(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic wait_idle(input string name, input int maxc);
    int n;
    n  = 0;
    we = 1'b0;
    a  = A_STATUS;
    #1;
    while (n < maxc && !(rd == 32'h4 && exp_q.size() == 0)) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (n >= maxc) begin
      failures++;
      $display("FAIL %s: still busy after %0d cycles status=%h pending=%0d", name, n, rd, exp_q.size());
    end
  endtask

  // UART receiver: pops the expected frame at each start bit
  initial begin : monitor
    logic   prev, bitv;
    logic [7:0] got;
    frame_t e;
    bit     ok, ab;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev = 1'b1;
      end else if (prev && !tx) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_frame: tx fell at cycle %0d with no byte queued", cyc);
          prev = 1'b0;
        end else begin
          e  = exp_q.pop_front();
          starts.push_back(cyc);
          ab  = 1'b0;
          got = '0;
          for (int b = 0; b < 10 && !ab; b++) begin
            bitv = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : e.data[b-1];
            ok   = 1'b1;
            for (int c = 0; c < int'(e.lens[b]) && !ab; c++) begin
              if (b != 0 || c != 0) @(negedge clk);
              if (!reset) ab = 1'b1;
              else begin
                if (tx !== bitv) ok = 1'b0;
                if (c == 0 && b >= 1 && b <= 8) got[b-1] = tx;
              end
            end
            if (!ab) begin
              checks++;
              if (!ok) begin
                failures++;
                $display("FAIL frame_bit%0d byte %h: tx level/duration wrong, required %b for %0d cycles",
                         b, e.data, bitv, e.lens[b]);
              end
            end
          end
          if (!ab) check("frame_byte", {24'h0, got}, {24'h0, e.data});
          prev = ab ? 1'b1 : tx;
        end
      end else begin
        prev = tx;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int e0, en;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    rd_chk("status_during_reset", A_STATUS, 32'h4);
    check("tx_during_reset", tx, 32'h1);
    reset = 1'b1;

    // register map after reset
    rd_chk("txdata_reads0", A_TXDATA, 32'h0);
    rd_chk("status_reset", A_STATUS, 32'h4);
    rd_chk("div_reset", A_DIV, 32'd434);
    rd_chk("rsvd_reads0", A_RSVD, 32'h0);
    rd_chk("a10_ignored", BASE + 32'd6, 32'h4);
    check("sel_hit", sel, 32'h1);
    rd_chk("unselected_rd", 32'h0000_0000, 32'h0);
    check("sel_miss", sel, 32'h0);
    check("tx_idle", tx, 32'h1);

    // single 0x55 frame at div 4, busy window
    bus_write(A_DIV, 32'd4, en);
    rd_chk("div4", A_DIV, 32'd4);
    bus_write(A_TXDATA, 32'h55, e0);
    exp_q.push_back(mk(8'h55, 4, 4));
    rd_chk("count_after_push", A_STATUS, 32'h10);
    wait_cyc(e0 + 5);
    rd_chk("busy_mid_frame", A_STATUS, 32'h5);
    wait_cyc(e0 + 40);
    rd_chk("busy_last_stop", A_STATUS, 32'h5);
    wait_cyc(e0 + 41);
    rd_chk("idle_after_41", A_STATUS, 32'h4);
    wait_idle("frame55", 100);

    // burst of 9, overflow, clear, push accepted while full on pop edge
    for (int i = 0; i < 9; i++) begin
      bus_write(A_TXDATA, 32'h10 + i, en);
      if (i == 0) e0 = en;
      exp_q.push_back(mk(8'(8'h10 + i), 4, 4));
    end
    rd_chk("full_no_ovf", A_STATUS, 32'h83);
    bus_write(A_TXDATA, 32'hEE, en);
    rd_chk("ovf_set", A_STATUS, 32'h8B);
    bus_write(A_STATUS, 32'h8, en);
    rd_chk("ovf_cleared", A_STATUS, 32'h83);
    wait_cyc(e0 + 41);
    rd_chk("full_idle_gap", A_STATUS, 32'h82);
    bus_write(A_TXDATA, 32'h77, en);
    exp_q.push_back(mk(8'h77, 4, 4));
    check("pushpop_edge", en, e0 + 42);
    rd_chk("pushpop_no_ovf", A_STATUS, 32'h83);
    wait_idle("burst", 1000);

    // two frames at div 2 separated by one idle cycle
    bus_write(A_DIV, 32'd2, en);
    starts.delete();
    bus_write(A_TXDATA, 32'hA3, en);
    exp_q.push_back(mk(8'hA3, 2, 2));
    bus_write(A_TXDATA, 32'h0F, en);
    exp_q.push_back(mk(8'h0F, 2, 2));
    wait_idle("pair", 200);
    check("pair_frames", starts.size(), 32'd2);
    if (starts.size() == 2) check("pair_gap", starts[1] - starts[0], 32'd21);

    // divisor zero clamp, upper bits, mid-frame change
    bus_write(A_DIV, 32'd0, en);
    rd_chk("div_zero_is1", A_DIV, 32'd1);
    bus_write(A_DIV, 32'hABCD_0004, en);
    rd_chk("div_upper_ignored", A_DIV, 32'd4);
    bus_write(A_TXDATA, 32'h5A, e0);
    exp_q.push_back(mk(8'h5A, 4, 8));
    wait_cyc(e0 + 1);
    bus_write(A_DIV, 32'd8, en);
    wait_idle("div_change", 200);

    // reset during data bits abandons frame and FIFO contents
    bus_write(A_DIV, 32'd4, en);
    bus_write(A_TXDATA, 32'hC3, e0);
    exp_q.push_back(mk(8'hC3, 4, 4));
    bus_write(A_TXDATA, 32'h3C, en);
    wait_cyc(e0 + 14);
    check("tx_low_before_reset", tx, 32'h0);
    #2;
    reset = 1'b0;
    #1;
    check("tx_async_reset", tx, 32'h1);
    rd_chk("status_in_reset", A_STATUS, 32'h4);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    rd_chk("status_after_release", A_STATUS, 32'h4);
    rd_chk("div_after_reset", A_DIV, 32'd434);
    repeat (60) @(negedge clk);
    check("tx_idle_after_reset", tx, 32'h1);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter. It is a bus responder on the processor data port (MemWrite, DataAdr, WriteData, ReadData) and sits beside mem_map in the top-level decode.
- Processor stores push bytes into an internal FIFO.
- An FSM serialises each byte as 8N1 on tx.
- Loads return status and configuration combinationally, so single-cycle core timing is preserved.

Parameters:
BASE_ADDR, 32'h0000_0400, base of the 16-byte register window; a hit requires a[31:4] == BASE_ADDR[31:4].
DEPTH, 8, FIFO entries; must be a power of 2, ≥2.
DIV_RESET, 16'd434, reset baud divisor in clk cycles per bit (50 MHz / 115200).

Ports:
clk  in  1  system clock, all state on rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset asserted).
we  in  1  store strobe from core (MemWrite).
a  in  32  byte address (DataAdr).
wd  in  32  store data (WriteData).
rd  out  32  load data; combinational from a; 32'h0 when not selected.
sel  out  1  combinational window hit, used by the top-level read mux.
tx  out  1  serial line, idle high.

Behaviour:
- Reset (reset=0, async):
  - FIFO empty; state IDLE; tx=1; div=DIV_RESET.
  - Overflow flag=0; bit counter=0; baud counter=0.
  - rd follows a even during reset (it reflects the reset register values).
- Register map (offset = a[3:2]):
  - 0 TXDATA: write pushes wd[7:0]; read returns 0.
  - 1 STATUS (read): [0] busy (state≠IDLE), [1] full, [2] empty, [3] overflow, [7:4] count (saturates at 15), rest 0. Write with wd[3]=1 clears overflow; other bits are ignored.
  - 2 BAUDDIV: R/W on [15:0]; upper bits read 0. A write of 0 stores 1.
  - 3 reserved: reads 0, writes ignored.
  - a[1:0] ignored.
- Push:
  - Occurs when we && sel && offset 0; the entry is visible (count+1) after the same edge.
  - Push when full → data dropped, overflow set.
  - Exception: if the FSM pops in the same cycle, the push is accepted and there is no overflow.
- FSM, states IDLE, START, DATA, STOP:
  - IDLE: tx=1. If FIFO non-empty at an edge: pop head into shift register, baud counter=div-1, go START. A byte pushed into an empty FIFO at edge N is popped at edge N+1, so tx falls after N+1.
  - START: tx=0 for div cycles.
  - DATA: tx=shift[0], LSB first, 8 bits of div cycles each; shift right at each bit end.
  - STOP: tx=1 for div cycles, then IDLE. A non-empty FIFO is popped at the next edge, so there is one idle cycle between frames.
  - Frame length = 10·div cycles, plus 1 IDLE cycle per byte.
- Baud counter:
  - Decrements each cycle; bit end when it is 0, then it reloads div-1.
  - A div write mid-frame takes effect at the next reload; the current bit is not truncated.
- Boundary cases:
  - FIFO pointers wrap modulo DEPTH; full/empty are distinguished by an extra pointer bit.
  - Reset mid-frame: tx goes high immediately and the frame is abandoned.
  - Simultaneous clear-overflow write and overflowing push cannot occur (a single bus access per cycle).

Decomposition:
- Package mmio_uart_pkg:
  - Register offset constants (REG_TXDATA..REG_RSVD).
  - STATUS bit indices.
  - typedef enum logic [1:0] tx_state_t {IDLE, START, DATA, STOP}.
- One sub-module: sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count, same clk/reset). The FSM, register decode and read mux stay in mmio_uart_tx.

Test Plan:
- Reset, then read all offsets → STATUS=32'h0000_0004, BAUDDIV=434, tx=1, sel=0 for a=32'h0000_0000.
- DIV=4; write 0x55 to TXDATA at edge N → tx low from N+1 for 4 cycles, then bits 1,0,1,0,1,0,1,0 each 4 cycles, stop high 4 cycles. STATUS busy=1 during the frame, 0 after 41 cycles.
- DIV=4; push 9 bytes back-to-back, with the first popped after one cycle → no overflow. Then push until full → count=8, the next push sets STATUS[3]=1. Write STATUS wd=8 → overflow=0.
- Push 0xA3, 0x0F with DIV=2 → two frames separated by exactly one idle-high cycle; captured bytes match in order.
- Write BAUDDIV=0 → reads 1. Write BAUDDIV=8 mid-frame at DIV=4 → the current bit stays 4 cycles, subsequent bits are 8.
- Assert reset mid-DATA → tx=1 asynchronously, FIFO empty, STATUS=4 after release, no residual frame.
